i2s_tx: RTL and testbench

I2S transmitter that serialises stereo samples from the Karplus-Strong voice into `i2s_sck`, `i2s_ws` and `i2s_sd`, which drive the uio pins. It sits directly downstream of the KS string engine. A valid/ready handshake feeds it through a one-entry staging buffer. It generates the bit clock internally from `clk`. On starvation it repeats the last sample and raises a sticky underrun flag that the SPI status map can read.

---
 rtl/ks_audio_pkg.sv | 15 +
 rtl/i2s_tx_if.sv | 18 +
 rtl/i2s_sck_gen.sv | 51 +++++
 rtl/i2s_tx.sv | 145 ++++++++++++++
 tb/tb_i2s_tx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_audio_pkg.sv
// Shared audio definitions for the Karplus-Strong voice and its I2S output stage.
//   AUDIO_DW   : per-channel sample width produced by the string engine
//   FRAME_BITS : bits per stereo I2S frame (left word followed by right word)
//   stereo_t   : one left/right sample pair as carried between blocks
package ks_audio_pkg;

    localparam int AUDIO_DW   = 8;
    localparam int FRAME_BITS = 2 * AUDIO_DW;

    typedef struct packed {
        logic [AUDIO_DW-1:0] l;
        logic [AUDIO_DW-1:0] r;
    } stereo_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair stream from the KS string engine into the I2S transmitter.
//   l_data / r_data : left / right two's-complement samples
//   s_valid         : pair is valid (driven by the source)
//   s_ready         : transmitter staging buffer is empty (driven by the sink)
// Modports: master = sample source, slave = transmitter.
interface i2s_tx_if
    import ks_audio_pkg::*;
#(
    parameter int DW = AUDIO_DW
);
    logic [DW-1:0] l_data;
    logic [DW-1:0] r_data;
    logic          s_valid;
    logic          s_ready;

    modport master (output l_data, output r_data, output s_valid, input s_ready);
    modport slave  (input l_data, input r_data, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: divides clk by 2*SCK_DIV.
//   clk, rst : system clock, synchronous active-high reset
//   en       : run enable; while low the divider and sck sit at 0
//   sck      : registered bit clock
//   sck_fall : one-clk strobe on the clk edge where sck goes 1->0
//   sck_rise : one-clk strobe on the clk edge where sck goes 0->1
// The strobes are combinational so the consumer acts on the same clk edge
// that moves sck.
module i2s_sck_gen
    import ks_audio_pkg::*;
#(
    parameter int SCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic sck_fall,
    output logic sck_rise
);
    localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [CW-1:0] div_cnt_r;
    logic          sck_r;
    logic          tc_s;

    // Terminal count of the half-period divider.
    always_comb begin
        tc_s = en && (div_cnt_r == CW'(SCK_DIV - 1));
    end

    // Half-period counter and bit-clock toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {CW{1'b0}};
            sck_r     <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= {CW{1'b0}};
            sck_r     <= 1'b0;
        end else if (tc_s) begin
            div_cnt_r <= {CW{1'b0}};
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    assign sck      = sck_r;
    assign sck_fall = tc_s && sck_r;
    assign sck_rise = tc_s && !sck_r;
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter for the KS voice.
//   clk, rst     : system clock, synchronous active-high reset
//   en           : transmitter enable; low holds the serialiser in reset,
//                  the staging buffer and last-sample copy are kept
//   s_if         : sample-pair stream (slave side), one-entry staging buffer
//   i2s_sck      : bit clock, clk / (2*SCK_DIV)
//   i2s_ws       : word select, 0 = left, 1 = right, leads the MSB by one sck
//   i2s_sd       : serial data, MSB first, changes on sck falling edges
//   frame_start  : one-clk pulse after the edge that enters slot 0
//   underrun     : sticky, set when a frame starts with staging empty
//   underrun_clr : clears underrun (a simultaneous new underrun wins)
module i2s_tx
    import ks_audio_pkg::*;
#(
    parameter int DW      = AUDIO_DW,
    parameter int SCK_DIV = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    i2s_tx_if.slave  s_if,
    output logic     i2s_sck,
    output logic     i2s_ws,
    output logic     i2s_sd,
    output logic     frame_start,
    output logic     underrun,
    input  logic     underrun_clr
);
    localparam int FB = 2 * DW;
    localparam int BW = $clog2(FB);

    logic [DW-1:0] stage_l_r;
    logic [DW-1:0] stage_r_r;
    logic          full_r;
    logic [FB-1:0] shift_r;
    logic [FB-1:0] last_r;
    logic [BW-1:0] bit_cnt_r;
    logic          ws_r;
    logic          frame_start_r;
    logic          underrun_r;

    logic          sck_s;
    logic          sck_fall_s;
    logic          sck_rise_unused_s;
    logic [BW-1:0] bit_nxt_s;
    logic          slot0_s;
    logic          take_s;
    logic          ws_nxt_s;

    i2s_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sck      (sck_s),
        .sck_fall (sck_fall_s),
        .sck_rise (sck_rise_unused_s)
    );

    // Next slot number, slot-0 entry, handshake transfer and WS decode.
    // WS is decoded from the slot being entered so it is high for slots
    // DW-1..2DW-2, one sck ahead of the right word.
    always_comb begin
        if (bit_cnt_r == BW'(FB - 1)) begin
            bit_nxt_s = {BW{1'b0}};
        end else begin
            bit_nxt_s = bit_cnt_r + 1'b1;
        end
        slot0_s  = sck_fall_s && (bit_cnt_r == BW'(FB - 1));
        take_s   = s_if.s_valid && !full_r;
        ws_nxt_s = (bit_nxt_s >= BW'(DW - 1)) && (bit_nxt_s <= BW'(FB - 2));
    end

    // One-entry staging buffer. A drain at slot 0 only happens while full,
    // and a transfer only while empty, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r    <= 1'b0;
            stage_l_r <= {DW{1'b0}};
            stage_r_r <= {DW{1'b0}};
        end else if (slot0_s && full_r) begin
            full_r    <= 1'b0;
        end else if (take_s) begin
            full_r    <= 1'b1;
            stage_l_r <= s_if.l_data;
            stage_r_r <= s_if.r_data;
        end else begin
            full_r    <= full_r;
        end
    end

    // Serialiser: slot counter, shift register, last-sample copy, WS, frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r     <= BW'(FB - 1);
            shift_r       <= {FB{1'b0}};
            last_r        <= {FB{1'b0}};
            ws_r          <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (!en) begin
            bit_cnt_r     <= BW'(FB - 1);
            shift_r       <= {FB{1'b0}};
            ws_r          <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= slot0_s;
            if (sck_fall_s) begin
                bit_cnt_r <= bit_nxt_s;
                ws_r      <= ws_nxt_s;
                if (slot0_s) begin
                    if (full_r) begin
                        shift_r <= {stage_l_r, stage_r_r};
                        last_r  <= {stage_l_r, stage_r_r};
                    end else begin
                        // Starved: repeat the previous pair.
                        shift_r <= last_r;
                    end
                end else begin
                    shift_r <= {shift_r[FB-2:0], 1'b0};
                end
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Sticky underrun flag; setting takes priority over clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_r <= 1'b0;
        end else if (slot0_s && !full_r) begin
            underrun_r <= 1'b1;
        end else if (underrun_clr) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign s_if.s_ready = !full_r;
    assign i2s_sck      = sck_s;
    assign i2s_ws       = ws_r;
    assign i2s_sd       = shift_r[FB-1];
    assign frame_start  = frame_start_r;
    assign underrun     = underrun_r;
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus pushes the expected {L,R} frame of
// every frame it causes; monitors decode sd on sck rising edges, latch a word
// on each ws change and pop/compare whenever a right word completes.
// Instance A uses SCK_DIV=2, instance B uses SCK_DIV=1.
module tb_i2s_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- instance A (SCK_DIV = 2, 64-clk frame) ----------------
    logic rst, en, ur_clr, sck, ws, sd, fs, ur;
    i2s_tx_if #(.DW(8)) ifa ();
    i2s_tx #(.DW(8), .SCK_DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .s_if(ifa),
        .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
        .frame_start(fs), .underrun(ur), .underrun_clr(ur_clr)
    );

    // ---------------- instance B (SCK_DIV = 1, 32-clk frame) ----------------
    logic rst_b, en_b, ur_clr_b, sck_b, ws_b, sd_b, fs_b, ur_b;
    i2s_tx_if #(.DW(8)) ifb ();
    i2s_tx #(.DW(8), .SCK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .s_if(ifb),
        .i2s_sck(sck_b), .i2s_ws(ws_b), .i2s_sd(sd_b),
        .frame_start(fs_b), .underrun(ur_b), .underrun_clr(ur_clr_b)
    );

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    bit          b_done = 1'b0;

    // Monitor A: frame decode and ws period.
    logic [15:0] acc_a;
    logic        psck_a, pws_a, pwsr_a;
    int          cyc_a = 0, wsr_t_a = 0;
    bit          wsr_ok_a;
    always @(posedge clk) begin
        #1;
        cyc_a++;
        if (rst || !en) begin
            psck_a = 1'b0; pws_a = 1'b0; pwsr_a = 1'b0; acc_a = 16'h0000; wsr_ok_a = 1'b0;
        end else begin
            if (ws && !pwsr_a) begin
                if (wsr_ok_a) chk("a_ws_period", cyc_a - wsr_t_a, 32'd64);
                wsr_t_a  = cyc_a;
                wsr_ok_a = 1'b1;
            end
            pwsr_a = ws;
            if (sck && !psck_a) begin
                acc_a = {acc_a[14:0], sd};
                if (ws != pws_a) begin
                    if (pws_a) begin
                        if (qa.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL a_frame_unexpected: got 0x%0h, expected none", acc_a);
                        end else begin
                            chk("a_frame", {16'h0000, acc_a}, {16'h0000, qa.pop_front()});
                        end
                    end
                    pws_a = ws;
                end
            end
            psck_a = sck;
        end
    end

    // Monitor B: frame decode, ws period, sck toggling every clk.
    logic [15:0] acc_b;
    logic        psck_b, pws_b, pwsr_b, tsck_b;
    int          cyc_b = 0, wsr_t_b = 0, nt_b = 0;
    bit          wsr_ok_b;
    always @(posedge clk) begin
        #1;
        cyc_b++;
        if (!rst_b && en_b && (sck_b == tsck_b)) nt_b++;
        tsck_b = sck_b;
        if (rst_b || !en_b) begin
            psck_b = 1'b0; pws_b = 1'b0; pwsr_b = 1'b0; acc_b = 16'h0000; wsr_ok_b = 1'b0;
        end else begin
            if (ws_b && !pwsr_b) begin
                if (wsr_ok_b) chk("b_ws_period", cyc_b - wsr_t_b, 32'd32);
                wsr_t_b  = cyc_b;
                wsr_ok_b = 1'b1;
            end
            pwsr_b = ws_b;
            if (sck_b && !psck_b) begin
                acc_b = {acc_b[14:0], sd_b};
                if (ws_b != pws_b) begin
                    if (pws_b) begin
                        if (qb.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL b_frame_unexpected: got 0x%0h, expected none", acc_b);
                        end else begin
                            chk("b_frame", {16'h0000, acc_b}, {16'h0000, qb.pop_front()});
                        end
                    end
                    pws_b = ws_b;
                end
            end
            psck_b = sck_b;
        end
    end

    // Wait (bounded) for the next frame_start; n = negedges waited.
    task automatic wait_fs(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fs) begin
                n = i + 1;
                return;
            end
        end
        vectors++; miscompares++;
        $display("FAIL a_fs_timeout: got no frame_start, expected one within 300 cycles");
    endtask

    task automatic wait_fs_b(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ifb.s_valid = 1'b0;
            if (fs_b) begin
                n = i + 1;
                return;
            end
        end
        vectors++; miscompares++;
        $display("FAIL b_fs_timeout: got no frame_start, expected one within 300 cycles");
    endtask

    // Offer a pair on A (called at a negedge); waited = edges spent stalled.
    task automatic send_a(input logic [7:0] l, input logic [7:0] r, output int waited);
        logic rdy;
        ifa.l_data = l; ifa.r_data = r; ifa.s_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 300; i++) begin
            rdy = ifa.s_ready;
            @(posedge clk);
            if (rdy) begin
                @(negedge clk);
                ifa.s_valid = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
        end
        ifa.s_valid = 1'b0;
        vectors++; miscompares++;
        $display("FAIL a_send_timeout: got no s_ready, expected one within 300 cycles");
    endtask

    // Stimulus for instance B.
    initial begin
        int n;
        rst_b = 1'b1; en_b = 1'b0; ur_clr_b = 1'b0;
        ifb.s_valid = 1'b0; ifb.l_data = 8'h00; ifb.r_data = 8'h00;
        repeat (4) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        ifb.l_data = 8'h80; ifb.r_data = 8'h01; ifb.s_valid = 1'b1; en_b = 1'b1;
        qb.push_back(16'h8001);
        qb.push_back(16'h8001);
        wait_fs_b(n);
        chk("b_first_fs_edge", n, 32'd2);
        chk("b_first_sd_msb", {31'd0, sd_b}, 32'd1);
        wait_fs_b(n);
        chk("b_underrun", {31'd0, ur_b}, 32'd1);
        wait_fs_b(n);
        en_b = 1'b0;
        @(negedge clk);
        chk("b_sck_toggle_misses", nt_b, 32'd0);
        b_done = 1'b1;
    end

    // Stimulus for instance A.
    initial begin
        int n, w, bad;
        rst = 1'b1; en = 1'b0; ur_clr = 1'b0;
        ifa.s_valid = 1'b0; ifa.l_data = 8'h00; ifa.r_data = 8'h00;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (sck !== 1'b0) bad++;
        end
        chk("rst_sck", {31'd0, sck}, 32'd0);
        chk("rst_ws", {31'd0, ws}, 32'd0);
        chk("rst_sd", {31'd0, sd}, 32'd0);
        chk("rst_fs", {31'd0, fs}, 32'd0);
        chk("rst_underrun", {31'd0, ur}, 32'd0);
        chk("rst_s_ready", {31'd0, ifa.s_ready}, 32'd1);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (sck !== 1'b0) bad++;
        end
        chk("sck_idle_while_disabled", bad, 32'd0);

        // Single pair, then two starved frames repeating it.
        qa.push_back(16'hA53C); qa.push_back(16'hA53C); qa.push_back(16'hA53C);
        en = 1'b1;
        send_a(8'hA5, 8'h3C, w);
        chk("accept_to_not_ready", {31'd0, ifa.s_ready}, 32'd0);
        wait_fs(n);
        chk("first_fs_edge", n, 32'd3);
        chk("drain_ready", {31'd0, ifa.s_ready}, 32'd1);
        chk("f1_underrun", {31'd0, ur}, 32'd0);
        chk("f1_sd_msb", {31'd0, sd}, 32'd1);
        chk("f1_ws_left", {31'd0, ws}, 32'd0);
        wait_fs(n);
        chk("f2_underrun_set", {31'd0, ur}, 32'd1);
        ur_clr = 1'b1;
        @(negedge clk);
        ur_clr = 1'b0;
        chk("underrun_cleared", {31'd0, ur}, 32'd0);
        ur_clr = 1'b1;
        wait_fs(n);
        chk("f3_set_beats_clr", {31'd0, ur}, 32'd1);
        ur_clr = 1'b0;

        // Back-pressure: second pair waits for the next slot-0 drain.
        qa.push_back(16'h1122); qa.push_back(16'h3344);
        send_a(8'h11, 8'h22, w);
        chk("bp_first_wait", w, 32'd0);
        send_a(8'h33, 8'h44, w);
        chk("bp_second_wait", w, 32'd63);
        wait_fs(n);
        chk("f5_ready", {31'd0, ifa.s_ready}, 32'd1);
        wait_fs(n);

        // en drop mid-frame.
        for (int i = 0; i < 100; i++) begin
            if (sck && ws && sd) break;
            @(negedge clk);
        end
        chk("pre_disable_active", {29'd0, sck, ws, sd}, 32'd7);
        en = 1'b0;
        @(negedge clk);
        chk("dis_sck_ws_sd_fs", {28'd0, sck, ws, sd, fs}, 32'd0);
        chk("dis_underrun_kept", {31'd0, ur}, 32'd1);
        en = 1'b1;
        wait_fs(n);
        chk("reenable_fs_edge", n, 32'd4);

        // Reset mid-frame with a pair sitting in staging.
        send_a(8'h55, 8'h66, w);
        repeat (19) @(negedge clk);
        chk("pre_rst_full", {31'd0, ifa.s_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sck_ws_sd_fs", {28'd0, sck, ws, sd, fs}, 32'd0);
        chk("mid_rst_underrun", {31'd0, ur}, 32'd0);
        chk("mid_rst_flush", {31'd0, ifa.s_ready}, 32'd1);
        rst = 1'b0;
        qa.push_back(16'h0000);
        wait_fs(n);
        chk("post_rst_fs_edge", n, 32'd4);
        chk("post_rst_underrun", {31'd0, ur}, 32'd1);
        wait_fs(n);
        en = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2000; i++) begin
            if (b_done) break;
            @(negedge clk);
        end
        chk("b_done", {31'd0, b_done}, 32'd1);
        chk("a_frames_left", qa.size(), 32'd0);
        chk("b_frames_left", qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
